vote_session_ctrl: RTL
======================

// Module: vote_session_ctrl
// PURPOSE
//  Ballot sequencer in front of voting_machine. Synchronises and debounces raw candidate
//  buttons, allows exactly one vote per officer "arm", rejects ambiguous multi-presses and
//  drives voting_machine's mode (0 = vote, 1 = result display) and one-hot vote strobes.
// PARAMETERS
//  N_CAND          4     number of candidate buttons
//  DEBOUNCE_CYCLES 16    consecutive stable synchronised samples needed to change a button level
//  ARM_TIMEOUT     1000  cycles in ARMED with no vote before returning to IDLE
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  reset       in   1       asynchronous, active-low reset
//  arm         in   1       officer enable; raw and asynchronous, rising edge after sync = new ballot
//  result_req  in   1       raw level; 1 = request result display
//  cand_btn    in   N_CAND  raw asynchronous candidate buttons, active-high
//  vote_pulse  out  N_CAND  one-hot, single-cycle strobe to the vote counters
//  ballot_done out  1       single-cycle pulse, coincident with vote_pulse
//  err_multi   out  1       single-cycle pulse on an ambiguous press
//  armed       out  1       1 while in ARMED
//  mode        out  1       to voting_machine: 0 = vote, 1 = result
//  disp_sel    out  N_CAND  debounced button levels in RESULT, 0 otherwise
//  state_o     out  3       current state encoding (debug)
// BEHAVIOUR
//  - Reset: every output 0. State IDLE. Sync flops, debounce counters and levels cleared.
//    Reset mid-operation aborts the ballot; no vote is emitted.
//  - Input path: 2-flop synchroniser on cand_btn, arm and result_req. Per-button debouncer
//    flips its level after DEBOUNCE_CYCLES equal samples. Press event = 0->1 of debounced level.
//    arm and result_req are synchronised only, not debounced.
//  - Latency: for a clean press, vote_pulse asserts 2 + DEBOUNCE_CYCLES + 1 cycles after the raw edge.
//  - IDLE: mode=0. Synced arm rising edge -> ARMED, with ARM_TIMEOUT counter cleared.
//    Else result_req=1 -> RESULT. Arm edge and result_req in the same cycle: arm wins.
//    Press events in IDLE are discarded.
//  - ARMED: armed=1. Timer counts each cycle.
//    Exactly one press event while every other debounced level is 0 -> CAST.
//    Two or more press events in the same cycle, or a press while any other level is already 1:
//    err_multi pulse, ballot not consumed, stay ARMED.
//    A button held across entry to ARMED gives no edge and no vote.
//    Timer reaches ARM_TIMEOUT-1 -> IDLE with no vote; a valid press in that same cycle wins (CAST).
//    arm and result_req are ignored.
//  - CAST: exactly one cycle. vote_pulse = one-hot of the pressed button, ballot_done=1.
//    -> RELEASE_WAIT.
//  - RELEASE_WAIT: wait until all debounced levels are 0, then -> IDLE. All presses ignored.
//    This guarantees one vote per press and per arm.
//  - RESULT: mode=1, disp_sel = debounced levels, vote_pulse held 0. Synced result_req=0 -> IDLE.
//    Multiple buttons are passed through unfiltered.
//  - Timer width is $clog2(ARM_TIMEOUT). No wrap: the timer saturates by leaving ARMED.
//  - Outputs are registered. vote_pulse, ballot_done and err_multi are never asserted for
//    2 consecutive cycles.
// STRUCTURE
//  - Package vote_pkg: state encoding (IDLE=0, ARMED=1, CAST=2, RELEASE_WAIT=3, RESULT=4),
//    N_CAND default, and mode constants MODE_VOTE / MODE_RESULT.
//  - Sub-module btn_debounce: synchroniser + counter + level + rise strobe for one button.
//    Instantiated N_CAND times in a generate loop.
//  - Top level holds the FSM, press arbitration (popcount of rise vector) and ARM timer.
// TESTING
//  1. Reset, arm, hold cand_btn[0] for 40 cycles -> one vote_pulse=0001 with ballot_done;
//     after release + debounce, state IDLE.
//  2. No arm, press cand_btn[1] for 40 cycles -> vote_pulse stays 0000, state IDLE throughout.
//  3. Arm, raise cand_btn[1] and cand_btn[2] in the same cycle -> one err_multi pulse, no vote,
//     armed=1. Release both, press cand_btn[2] alone -> vote_pulse=0100.
//  4. Arm, toggle cand_btn[3] every 3 cycles for 30 cycles, then hold -> exactly one
//     vote_pulse=1000, DEBOUNCE_CYCLES+3 cycles after the final edge.
//  5. result_req=1 in IDLE -> mode=1 within 3 cycles. Hold cand_btn[1] -> disp_sel=0010,
//     vote_pulse=0000. Drop result_req -> mode=0.
//  6. Arm, no press for ARM_TIMEOUT cycles -> armed=0, state IDLE.
//     Separately, assert reset during RELEASE_WAIT -> all outputs 0 immediately, no clock needed.

Source files
------------

// File: rtl/vote_pkg.sv
// vote_pkg: shared state encodings, mode constants and default sizing for the ballot sequencer
package vote_pkg;
  localparam int N_CAND_DEF = 4;
  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_ARMED        = 3'd1;
  localparam logic [2:0] ST_CAST         = 3'd2;
  localparam logic [2:0] ST_RELEASE_WAIT = 3'd3;
  localparam logic [2:0] ST_RESULT       = 3'd4;
  localparam logic MODE_VOTE   = 1'b0;
  localparam logic MODE_RESULT = 1'b1;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter, debounced level and rise strobe for one button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d, rise_q, rise_d, differ, flip;
  // level flips once the synchronised sample has disagreed with it DEBOUNCE_CYCLES times in a row
  always_comb begin
    differ  = sync_q[1] != level_q;
    flip    = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d   = (!differ || flip) ? '0 : cnt_q + CW'(1);
    level_d = flip ? ~level_q : level_q;
    rise_d  = flip & ~level_q;
  end
  // synchroniser, counter, level and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end
  assign level_o = level_q;
  assign rise_o  = rise_q;
endmodule

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: ballot sequencer allowing one debounced, unambiguous vote per officer arm
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int N_CAND          = N_CAND_DEF,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ARM_TIMEOUT     = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              result_req,
  input  logic [N_CAND-1:0] cand_btn,
  output logic [N_CAND-1:0] vote_pulse,
  output logic              ballot_done,
  output logic              err_multi,
  output logic              armed,
  output logic              mode,
  output logic [N_CAND-1:0] disp_sel,
  output logic [2:0]        state_o
);
  localparam int TW = $clog2(ARM_TIMEOUT);
  logic [N_CAND-1:0] lvl, rise;
  logic [1:0]        arm_sync_q, req_sync_q;
  logic              arm_prev_q, arm_rise;
  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [N_CAND-1:0] vote_q, vote_d, disp_q;
  logic              done_q, done_d, err_q, err_d, armed_q, mode_q;
  logic              multi, others_busy, valid, ambiguous;
  for (genvar i = 0; i < N_CAND; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (reset),
      .btn_i  (cand_btn[i]),
      .level_o(lvl[i]),
      .rise_o (rise[i])
    );
  end
  // press arbitration: a vote needs exactly one rise and no other button already down
  always_comb begin
    multi       = (rise & (rise - N_CAND'(1))) != '0;
    others_busy = |(lvl & ~rise);
    valid       = |rise && !multi && !others_busy;
    ambiguous   = multi || (|rise && others_busy);
    arm_rise    = arm_sync_q[1] & ~arm_prev_q;
  end
  // ballot FSM with arm timer; err_multi is suppressed right after a previous pulse
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    vote_d  = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_rise) begin
          state_d = ST_ARMED;
          timer_d = '0;
        end else if (req_sync_q[1]) begin
          state_d = ST_RESULT;
        end
      end
      ST_ARMED: begin
        timer_d = timer_q + TW'(1);
        if (valid) begin
          state_d = ST_CAST;
          vote_d  = rise;
          done_d  = 1'b1;
        end else begin
          err_d = ambiguous & ~err_q;
          if (timer_q == TW'(ARM_TIMEOUT - 1)) state_d = ST_IDLE;
        end
      end
      ST_CAST:         state_d = ST_RELEASE_WAIT;
      ST_RELEASE_WAIT: state_d = |lvl ? ST_RELEASE_WAIT : ST_IDLE;
      ST_RESULT:       state_d = req_sync_q[1] ? ST_RESULT : ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end
  // synchronisers, state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arm_sync_q <= '0;
      req_sync_q <= '0;
      arm_prev_q <= 1'b0;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      vote_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
      mode_q     <= MODE_VOTE;
      disp_q     <= '0;
    end else begin
      arm_sync_q <= {arm_sync_q[0], arm};
      req_sync_q <= {req_sync_q[0], result_req};
      arm_prev_q <= arm_sync_q[1];
      state_q    <= state_d;
      timer_q    <= timer_d;
      vote_q     <= vote_d;
      done_q     <= done_d;
      err_q      <= err_d;
      armed_q    <= state_d == ST_ARMED;
      mode_q     <= (state_d == ST_RESULT) ? MODE_RESULT : MODE_VOTE;
      disp_q     <= (state_d == ST_RESULT) ? lvl : '0;
    end
  end
  assign vote_pulse  = vote_q;
  assign ballot_done = done_q;
  assign err_multi   = err_q;
  assign armed       = armed_q;
  assign mode        = mode_q;
  assign disp_sel    = disp_q;
  assign state_o     = state_q;
endmodule
